// File: rtl/fnn_pkg.sv
// Shared FNN definitions: serializer FSM state encoding and common widths.
package fnn_pkg;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  localparam int unsigned DATA_WIDTH_DEFAULT = 16;
  localparam int unsigned FRAME_CNT_W        = 16;

endpackage

// File: rtl/layer_out_serializer.sv
// Captures one layer's parallel neuron outputs and streams them word 0 first, one per cycle.
// Optional `LAYER_SER_STATS_EN builds a saturating accepted-frame counter on frame_count.
module layer_out_serializer
  import fnn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
  input  logic [NUM_NEURONS-1:0]            neuron_valid,
  output logic [DATA_WIDTH-1:0]             ser_data,
  output logic                              ser_valid,
  output logic                              busy,
  output logic                              overrun,
  output logic                              sync_err,
  output logic [FRAME_CNT_W-1:0]            frame_count
);

  localparam int unsigned CW = $clog2(NUM_NEURONS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_NEURONS - 1);

  ser_state_t                        state_q, state_n;
  logic [CW-1:0]                     cnt_q, cnt_n;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] frame_buf_q, frame_buf_n;
  logic [DATA_WIDTH-1:0]             ser_data_q, ser_data_n;
  logic                              ser_valid_q, ser_valid_n;
  logic                              overrun_q, overrun_n;
  logic                              sync_err_q, sync_err_n;
  logic [DATA_WIDTH-1:0]             cur_word;
  logic                              capture, partial;

  assign capture = &neuron_valid;
  assign partial = (|neuron_valid) & ~(&neuron_valid);

  always_comb begin
    cur_word = '0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      if (cnt_q == CW'(i)) cur_word = frame_buf_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    frame_buf_n = frame_buf_q;
    ser_data_n  = ser_data_q;
    ser_valid_n = 1'b0;
    overrun_n   = overrun_q | (capture & (state_q == SER_SHIFT));
    sync_err_n  = sync_err_q | partial;
    case (state_q)
      SER_IDLE: begin
        if (capture) begin
          frame_buf_n = neuron_out;
          ser_data_n  = neuron_out[DATA_WIDTH-1:0];
          ser_valid_n = 1'b1;
          cnt_n       = CW'(1);
          if (NUM_NEURONS > 1) state_n = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        ser_data_n  = cur_word;
        ser_valid_n = 1'b1;
        if (cnt_q == LAST) begin
          state_n = SER_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: state_n = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SER_IDLE;
      cnt_q       <= '0;
      frame_buf_q <= '0;
      ser_data_q  <= '0;
      ser_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      frame_buf_q <= frame_buf_n;
      ser_data_q  <= ser_data_n;
      ser_valid_q <= ser_valid_n;
      overrun_q   <= overrun_n;
      sync_err_q  <= sync_err_n;
    end
  end

  assign ser_data  = ser_data_q;
  assign ser_valid = ser_valid_q;
  assign busy      = (state_q == SER_SHIFT);
  assign overrun   = overrun_q;
  assign sync_err  = sync_err_q;

`ifdef LAYER_SER_STATS_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  // Counts only captures accepted in IDLE; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (capture && (state_q == SER_IDLE) && (frame_cnt_q != '1)) begin
      frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed self-checking bench for layer_out_serializer (N=4, 16-bit words).
module tb_layer_out_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] neuron_out = '0;
  logic [3:0]  neuron_valid = '0;
  logic [15:0] ser_data;
  logic        ser_valid;
  logic        busy;
  logic        overrun;
  logic        sync_err;
  logic [15:0] frame_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  layer_out_serializer #(.NUM_NEURONS(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .neuron_out(neuron_out), .neuron_valid(neuron_valid),
    .ser_data(ser_data), .ser_valid(ser_valid), .busy(busy), .overrun(overrun),
    .sync_err(sync_err), .frame_count(frame_count)
  );

  function automatic logic [63:0] pack(input logic [15:0] base);
    return {base + 16'd3, base + 16'd2, base + 16'd1, base};
  endfunction

  // Inputs change on the negedge; outputs are sampled on the negedge after each posedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; neuron_valid = '0; neuron_out = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; neuron_valid = '0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({ser_valid, busy, overrun, sync_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got v/b/o/s=%b expected 0000", {ser_valid, busy, overrun, sync_err});
    end
    vectors++;
    if (ser_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 0000", ser_data);
    end
    vectors++;
    if (frame_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_frame_count: got %h expected 0000", frame_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    neuron_out = pack(16'h0001); neuron_valid = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      neuron_valid = '0;
      vectors++;
      if (ser_valid !== (k <= 4)) begin
        miscompares++;
        $display("FAIL basic_valid T+%0d: got %b expected %b", k, ser_valid, (k <= 4));
      end
      vectors++;
      if (ser_data !== ((k <= 4) ? 16'(k) : 16'h0004)) begin
        miscompares++;
        $display("FAIL basic_data T+%0d: got %h expected %h", k, ser_data, ((k <= 4) ? 16'(k) : 16'h0004));
      end
      vectors++;
      if (busy !== (k <= 3)) begin
        miscompares++;
        $display("FAIL basic_busy T+%0d: got %b expected %b", k, busy, (k <= 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    do_reset();
    neuron_out = pack(16'h0001); neuron_valid = 4'hF;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 4) begin
        neuron_out = pack(16'h0011); neuron_valid = 4'hF;
      end else begin
        neuron_valid = '0;
      end
      exp = (k <= 4) ? 16'(k) : 16'(16'h0010 + k - 4);
      if (k == 9) exp = 16'h0014;
      vectors++;
      if (ser_valid !== (k <= 8)) begin
        miscompares++;
        $display("FAIL b2b_valid T+%0d: got %b expected %b", k, ser_valid, (k <= 8));
      end
      vectors++;
      if (ser_data !== exp) begin
        miscompares++;
        $display("FAIL b2b_data T+%0d: got %h expected %h", k, ser_data, exp);
      end
      vectors++;
      if (overrun !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_overrun T+%0d: got %b expected 0", k, overrun);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    neuron_out = pack(16'h0001); neuron_valid = 4'hF;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 2) begin
        neuron_out = pack(16'h0021); neuron_valid = 4'hF;
      end else begin
        neuron_valid = '0;
      end
      vectors++;
      if (ser_valid !== (k <= 4)) begin
        miscompares++;
        $display("FAIL ovr_valid T+%0d: got %b expected %b", k, ser_valid, (k <= 4));
      end
      vectors++;
      if (ser_data !== ((k <= 4) ? 16'(k) : 16'h0004)) begin
        miscompares++;
        $display("FAIL ovr_data T+%0d: got %h expected %h", k, ser_data, ((k <= 4) ? 16'(k) : 16'h0004));
      end
      vectors++;
      if (overrun !== (k >= 3)) begin
        miscompares++;
        $display("FAIL ovr_flag T+%0d: got %b expected %b", k, overrun, (k >= 3));
      end
    end
  endtask

  task automatic test_partial();
    do_reset();
    neuron_out = pack(16'h0041); neuron_valid = 4'b0111;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      neuron_valid = '0;
      vectors++;
      if ({ser_valid, busy, sync_err} !== 3'b001) begin
        miscompares++;
        $display("FAIL partial T+%0d: got v/b/s=%b expected 001", k, {ser_valid, busy, sync_err});
      end
    end
    vectors++;
    if (ser_data !== 16'h0000) begin
      miscompares++;
      $display("FAIL partial_data: got %h expected 0000", ser_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    neuron_valid = 4'b1000;
    @(negedge clk);
    neuron_out = pack(16'h0001); neuron_valid = 4'hF;
    @(negedge clk);                      // T+1: overrunning capture
    neuron_out = pack(16'h0051); neuron_valid = 4'hF;
    @(negedge clk);                      // T+2: reset asserted
    neuron_valid = '0; rst = 1'b1;
    vectors++;
    if ({overrun, sync_err} !== 2'b11) begin
      miscompares++;
      $display("FAIL mid_pre_flags: got o/s=%b expected 11", {overrun, sync_err});
    end
    @(negedge clk);                      // T+3
    rst = 1'b0;
    vectors++;
    if ({ser_valid, busy, overrun, sync_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset_flags: got v/b/o/s=%b expected 0000", {ser_valid, busy, overrun, sync_err});
    end
    vectors++;
    if (frame_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL mid_reset_frame_count: got %h expected 0000", frame_count);
    end
    @(negedge clk);
    vectors++;
    if (ser_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_abandoned: got ser_valid %b expected 0", ser_valid);
    end
    neuron_out = pack(16'h0061); neuron_valid = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      neuron_valid = '0;
      vectors++;
      if ({ser_valid, ser_data} !== {1'b1, 16'(16'h0060 + k)}) begin
        miscompares++;
        $display("FAIL mid_fresh T+%0d: got v=%b d=%h expected v=1 d=%h", k, ser_valid, ser_data, 16'(16'h0060 + k));
      end
    end
  endtask

  task automatic test_stats();
    logic [15:0] exp_mid, exp_end;
`ifdef LAYER_SER_STATS_EN
    exp_mid = 16'd1; exp_end = 16'd3;
`else
    exp_mid = 16'd0; exp_end = 16'd0;
`endif
    do_reset();
    neuron_out = pack(16'h0071);
    for (int k = 0; k <= 14; k++) begin
      neuron_valid = (k == 0 || k == 4 || k == 8 || k == 9) ? 4'hF : 4'h0;
      @(negedge clk);
      if (k == 2) begin
        vectors++;
        if (frame_count !== exp_mid) begin
          miscompares++;
          $display("FAIL stats_mid: got %0d expected %0d", frame_count, exp_mid);
        end
      end
    end
    neuron_valid = '0;
    vectors++;
    if (frame_count !== exp_end) begin
      miscompares++;
      $display("FAIL stats_end: got %0d expected %0d", frame_count, exp_end);
    end
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL stats_overrun: got %b expected 1", overrun);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_partial();
    test_reset_mid_frame();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
